pipe_stage_skid: RTL

Parametrised pipeline stage register with a valid/ready handshake, a one-entry skid buffer, synchronous flush, and a saturating stall-cycle counter. Each instance sits between two CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and carries a control field and a data field. Back-pressure can stall upstream without a combinational ready path. Flushed or empty slots always present a zero control word (bubble) downstream.

---
 rtl/pipe_pkg.sv | 43 ++++
 rtl/pipe_slot.sv | 58 +++++
 rtl/pipe_stage_skid.sv | 102 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the CPU pipeline stage registers: bubble constant,
// per-stage field widths and a lookup helper.
package pipe_pkg;

  localparam int unsigned BUBBLE_MAX_W = 256;
  localparam logic [BUBBLE_MAX_W-1:0] BUBBLE_CTRL = '0;

  typedef enum logic [1:0] {
    STAGE_IF_ID,
    STAGE_ID_EX,
    STAGE_EX_MEM,
    STAGE_MEM_WB
  } stage_e;

  // IF/ID carries no control bits yet; instantiate it with a data-only wrapper.
  localparam int unsigned IF_ID_CTRL_W  = 0;
  localparam int unsigned IF_ID_DATA_W  = 64;
  localparam int unsigned ID_EX_CTRL_W  = 16;
  localparam int unsigned ID_EX_DATA_W  = 170;
  localparam int unsigned EX_MEM_CTRL_W = 5;
  localparam int unsigned EX_MEM_DATA_W = 106;
  localparam int unsigned MEM_WB_CTRL_W = 3;
  localparam int unsigned MEM_WB_DATA_W = 104;

  function automatic int unsigned stage_ctrl_w(input stage_e s);
    case (s)
      STAGE_IF_ID:  return IF_ID_CTRL_W;
      STAGE_ID_EX:  return ID_EX_CTRL_W;
      STAGE_EX_MEM: return EX_MEM_CTRL_W;
      default:      return MEM_WB_CTRL_W;
    endcase
  endfunction

  function automatic int unsigned stage_data_w(input stage_e s);
    case (s)
      STAGE_IF_ID:  return IF_ID_DATA_W;
      STAGE_ID_EX:  return ID_EX_DATA_W;
      STAGE_EX_MEM: return EX_MEM_DATA_W;
      default:      return MEM_WB_DATA_W;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid + control + data register with clear and load.
// Clear zeroes valid and control but leaves data untouched.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned DATA_W = 96
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      ctrl_d  = BUBBLE_CTRL[CTRL_W-1:0];
    end else if (load_i) begin
      // An empty load only drops valid; payload keeps its last value.
      valid_d = valid_i;
      if (valid_i) begin
        ctrl_d = ctrl_i;
        data_d = data_i;
      end
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer,
// synchronous flush and a saturating stall-cycle counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned DATA_W = 96,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              m_valid, s_valid;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;
  logic [DATA_W-1:0] m_data, s_data;

  logic              in_fire;
  logic              m_take;
  logic              s_load;
  logic              m_in_valid;
  logic [CTRL_W-1:0] m_in_ctrl;
  logic [DATA_W-1:0] m_in_data;

  // Ready comes straight from the skid flop, so no combinational path feeds it.
  assign in_ready = ~s_valid;
  assign in_fire  = in_valid & in_ready;

  // M advances when empty or draining; S, if occupied, always goes first.
  assign m_take     = ~m_valid | out_ready;
  assign s_load     = m_valid & ~out_ready & in_fire;
  assign m_in_valid = s_valid | in_fire;
  assign m_in_ctrl  = s_valid ? s_ctrl : in_ctrl;
  assign m_in_data  = s_valid ? s_data : in_data;

  pipe_slot #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W)
  ) u_main (
    .sysclk  (sysclk),
    .reset   (reset),
    .clear_i (flush),
    .load_i  (m_take),
    .valid_i (m_in_valid),
    .ctrl_i  (m_in_ctrl),
    .data_i  (m_in_data),
    .valid_o (m_valid),
    .ctrl_o  (m_ctrl),
    .data_o  (m_data)
  );

  pipe_slot #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W)
  ) u_skid (
    .sysclk  (sysclk),
    .reset   (reset),
    .clear_i (flush | m_take),
    .load_i  (s_load),
    .valid_i (1'b1),
    .ctrl_i  (in_ctrl),
    .data_i  (in_data),
    .valid_o (s_valid),
    .ctrl_o  (s_ctrl),
    .data_o  (s_data)
  );

  assign out_valid = m_valid;
  assign out_ctrl  = m_valid ? m_ctrl : BUBBLE_CTRL[CTRL_W-1:0];
  assign out_data  = m_data;

  logic [CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (m_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // Flush deliberately leaves the stall statistic alone.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;

endmodule
